// File: rtl/conv_seq_pkg.sv
// Shared definitions for the convolution index sequencer: default index width
// and the sequencer state encoding.
package conv_seq_pkg;

  localparam int IDX_W_DEFAULT = 5;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    WRITE,
    DONE
  } state_e;

endpackage

// File: rtl/conv_index_seq_idx_bound_calc.sv
// Combinational bounds of the operand index i for output index k:
// i runs from max(0, k-(size_y-1)) to min(k, size_x-1).
module idx_bound_calc
  import conv_seq_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic [IDX_W:0] k_i,
  input  logic [IDX_W:0] size_x_i,
  input  logic [IDX_W:0] size_y_i,
  output logic [IDX_W:0] i_start_o,
  output logic [IDX_W:0] i_end_o
);

  localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};

  logic [IDX_W:0] x_last;
  logic [IDX_W:0] y_last;

  always_comb begin
    x_last    = size_x_i - ONE;
    y_last    = size_y_i - ONE;
    i_start_o = (k_i > y_last) ? (k_i - y_last) : '0;
    i_end_o   = (k_i < x_last) ? k_i : x_last;
  end

endmodule

// File: rtl/conv_index_seq.sv
// Convolution index sequencer: for each output k, issues the operand pairs (i, k-i)
// and a Z write. Optional zero-size rejection with err output: CONV_SEQ_SIZE_CHECK_EN.
module conv_index_seq
  import conv_seq_pkg::*;
#(
  parameter int IDX_W = IDX_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [IDX_W-1:0] size_x,
  input  logic [IDX_W-1:0] size_y,
  input  logic             ready,
  output logic             busy,
  output logic             done,
  output logic [IDX_W-1:0] x_addr,
  output logic [IDX_W-1:0] y_addr,
  output logic             mac_clr,
  output logic             mac_en,
  output logic             mac_last,
  output logic [IDX_W:0]   z_addr,
  output logic             z_wr
`ifdef CONV_SEQ_SIZE_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [IDX_W:0] ONE = {{IDX_W{1'b0}}, 1'b1};

  state_e         state_q;
  logic [IDX_W:0] sx_q;
  logic [IDX_W:0] sy_q;
  logic [IDX_W:0] k_q;
  logic [IDX_W:0] i_q;
  logic [IDX_W:0] j_q;
  logic [IDX_W:0] i_end_q;
  logic [IDX_W:0] z_addr_q;
  logic           busy_q;
  logic           done_q;
  logic           mac_clr_q;
  logic           z_wr_q;
`ifdef CONV_SEQ_SIZE_CHECK_EN
  logic           err_q;
`endif

  logic [IDX_W:0] i_start;
  logic [IDX_W:0] i_end;
  logic [IDX_W:0] k_last;
  logic           zero_size;
  logic           at_end;

  idx_bound_calc #(
    .IDX_W(IDX_W)
  ) u_bounds (
    .k_i      (k_q),
    .size_x_i (sx_q),
    .size_y_i (sy_q),
    .i_start_o(i_start),
    .i_end_o  (i_end)
  );

  assign k_last    = sx_q + sy_q - ONE - ONE;
  assign zero_size = (size_x == '0) || (size_y == '0);
  assign at_end    = (i_q == i_end_q);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= IDLE;
      sx_q      <= '0;
      sy_q      <= '0;
      k_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      i_end_q   <= '0;
      z_addr_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mac_clr_q <= 1'b0;
      z_wr_q    <= 1'b0;
`ifdef CONV_SEQ_SIZE_CHECK_EN
      err_q     <= 1'b0;
`endif
    end else begin
      done_q    <= 1'b0;
      mac_clr_q <= 1'b0;
      z_wr_q    <= 1'b0;
`ifdef CONV_SEQ_SIZE_CHECK_EN
      err_q     <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            if (zero_size) begin
`ifdef CONV_SEQ_SIZE_CHECK_EN
              err_q   <= 1'b1;
`else
              state_q <= DONE;
              busy_q  <= 1'b1;
              done_q  <= 1'b1;
`endif
            end else begin
              sx_q      <= {1'b0, size_x};
              sy_q      <= {1'b0, size_y};
              k_q       <= '0;
              state_q   <= LOAD;
              busy_q    <= 1'b1;
              mac_clr_q <= 1'b1;
            end
          end
        end
        LOAD: begin
          i_q     <= i_start;
          i_end_q <= i_end;
          j_q     <= k_q - i_start;
          state_q <= MAC;
        end
        MAC: begin
          // A stalled datapath (ready low) freezes the pair on the address bus.
          if (ready) begin
            if (at_end) begin
              state_q  <= WRITE;
              z_wr_q   <= 1'b1;
              z_addr_q <= k_q;
            end else begin
              i_q <= i_q + ONE;
              j_q <= j_q - ONE;
            end
          end
        end
        WRITE: begin
          if (k_q == k_last) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            k_q       <= k_q + ONE;
            state_q   <= LOAD;
            mac_clr_q <= 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mac_clr  = mac_clr_q;
  assign z_wr     = z_wr_q;
  assign z_addr   = z_addr_q;
  assign x_addr   = i_q[IDX_W-1:0];
  assign y_addr   = j_q[IDX_W-1:0];
  assign mac_en   = (state_q == MAC) && ready;
  assign mac_last = mac_en && at_end;
`ifdef CONV_SEQ_SIZE_CHECK_EN
  assign err      = err_q;
`endif

endmodule
